// File: rtl/ysyx_axi_arbiter.sv
// ysyx_axi_arbiter: round-robin N-to-1 arbiter onto a single-beat AXI4 master.
// Define YSYX_ARB_TIMEOUT_EN to add a per-transaction watchdog of TIMEOUT cycles.
module ysyx_axi_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int NREQ    = 3,
   parameter int TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ-1:0]        req_write,
   input  logic [NREQ*ADDR_W-1:0] req_addr,
   input  logic [NREQ*32-1:0]     req_wdata,
   input  logic [NREQ*4-1:0]      req_wstrb,
   output logic [NREQ-1:0]        req_ready,
   output logic [NREQ-1:0]        rsp_valid,
   output logic [31:0]            rsp_rdata,
   output logic                   rsp_err,
   output logic                   io_master_arvalid,
   input  logic                   io_master_arready,
   output logic [ADDR_W-1:0]      io_master_araddr,
   output logic [3:0]             io_master_arid,
   output logic [7:0]             io_master_arlen,
   output logic [2:0]             io_master_arsize,
   output logic [1:0]             io_master_arburst,
   input  logic                   io_master_rvalid,
   output logic                   io_master_rready,
   input  logic [1:0]             io_master_rresp,
   input  logic [63:0]            io_master_rdata,
   input  logic                   io_master_rlast,
   input  logic [3:0]             io_master_rid,
   output logic                   io_master_awvalid,
   input  logic                   io_master_awready,
   output logic [ADDR_W-1:0]      io_master_awaddr,
   output logic [3:0]             io_master_awid,
   output logic [7:0]             io_master_awlen,
   output logic [2:0]             io_master_awsize,
   output logic [1:0]             io_master_awburst,
   output logic                   io_master_wvalid,
   input  logic                   io_master_wready,
   output logic [63:0]            io_master_wdata,
   output logic [7:0]             io_master_wstrb,
   output logic                   io_master_wlast,
   input  logic                   io_master_bvalid,
   output logic                   io_master_bready,
   input  logic [1:0]             io_master_bresp,
   input  logic [3:0]             io_master_bid
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

   state_e              state_q, state_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [IW-1:0]       g_q, g_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [3:0]          mask_q, mask_d;
   logic                aw_done_q, aw_done_d;
   logic                w_done_q, w_done_d;
   logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
   logic [31:0]         rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;
`ifdef YSYX_ARB_TIMEOUT_EN
   logic [7:0]          cnt_q, cnt_d;
`endif

   logic                found;
   logic [IW-1:0]       grant_idx;
   int                  j;
   logic [3:0]          mshift;
   logic [2:0]          size;
   logic                ar_fire, aw_fire, w_fire, r_fire, b_fire;
   logic                unused_w;

   // first requester at or after the pointer, wrapping around
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      j         = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr_q) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found && req_valid[j]) begin
            found     = 1'b1;
            grant_idx = IW'(j);
         end
      end
   end

   always_comb begin
      mshift = mask_q;
      size   = 3'd2;
      if (mask_q[0])      mshift = mask_q;
      else if (mask_q[1]) mshift = mask_q >> 1;
      else if (mask_q[2]) mshift = mask_q >> 2;
      else                mshift = mask_q >> 3;
      case (mshift)
         4'b0001: size = 3'd0;
         4'b0011: size = 3'd1;
         default: size = 3'd2;
      endcase
   end

   assign io_master_arvalid = (state_q == S_ADDR) && !write_q;
   assign io_master_awvalid = (state_q == S_ADDR) && write_q && !aw_done_q;
   assign io_master_wvalid  = (state_q == S_ADDR) && write_q && !w_done_q;
   assign io_master_wlast   = io_master_wvalid;
   assign io_master_rready  = (state_q == S_DATA) && !write_q;
   assign io_master_bready  = (state_q == S_DATA) && write_q;

   assign io_master_araddr  = addr_q;
   assign io_master_awaddr  = addr_q;
   assign io_master_arid    = 4'(g_q);
   assign io_master_awid    = 4'(g_q);
   assign io_master_arlen   = 8'd0;
   assign io_master_awlen   = 8'd0;
   assign io_master_arburst = 2'b01;
   assign io_master_awburst = 2'b01;
   assign io_master_arsize  = size;
   assign io_master_awsize  = size;
   assign io_master_wdata   = {wdata_q, wdata_q};
   assign io_master_wstrb   = addr_q[2] ? {mask_q, 4'b0} : {4'b0, mask_q};

   assign ar_fire = io_master_arvalid && io_master_arready;
   assign aw_fire = io_master_awvalid && io_master_awready;
   assign w_fire  = io_master_wvalid && io_master_wready;
   assign r_fire  = io_master_rvalid && io_master_rready;
   assign b_fire  = io_master_bvalid && io_master_bready;

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   assign unused_w = ^{io_master_rlast, io_master_rid, io_master_bid,
                       8'(TIMEOUT)};

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      g_d         = g_q;
      write_d     = write_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mask_d      = mask_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      req_ready   = '0;
`ifdef YSYX_ARB_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (found && !rst) begin
               req_ready[grant_idx] = 1'b1;
               g_d       = grant_idx;
               write_d   = req_write[grant_idx];
               addr_d    = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
               wdata_d   = req_wdata[int'(grant_idx)*32 +: 32];
               mask_d    = req_wstrb[int'(grant_idx)*4 +: 4];
               ptr_d     = (grant_idx == IW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = S_ADDR;
`ifdef YSYX_ARB_TIMEOUT_EN
               cnt_d     = '0;
`endif
            end
         end
         S_ADDR: begin
            if (!write_q) begin
               if (ar_fire) state_d = S_DATA;
            end else begin
               aw_done_d = aw_done_q || aw_fire;
               w_done_d  = w_done_q || w_fire;
               if (aw_done_d && w_done_d) state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (r_fire) begin
               rsp_valid_d[g_q] = 1'b1;
               rsp_rdata_d = addr_q[2] ? io_master_rdata[63:32]
                                       : io_master_rdata[31:0];
               rsp_err_d   = |io_master_rresp;
               state_d     = S_IDLE;
            end else if (b_fire) begin
               rsp_valid_d[g_q] = 1'b1;
               rsp_rdata_d = '0;
               rsp_err_d   = |io_master_bresp;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
`ifdef YSYX_ARB_TIMEOUT_EN
      // a real completion in the last cycle wins over the watchdog
      if (state_q != S_IDLE) begin
         cnt_d = cnt_q + 8'd1;
         if (cnt_q == 8'(TIMEOUT-1) && state_d != S_IDLE) begin
            rsp_valid_d      = '0;
            rsp_valid_d[g_q] = 1'b1;
            rsp_err_d        = 1'b1;
            rsp_rdata_d      = '0;
            state_d          = S_IDLE;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         g_q         <= '0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mask_q      <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef YSYX_ARB_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         g_q         <= g_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         mask_q      <= mask_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
`ifdef YSYX_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_ysyx_axi_arbiter.sv
// tb_ysyx_axi_arbiter: directed self-checking bench for ysyx_axi_arbiter.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_ysyx_axi_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  req_valid, req_write, req_ready, rsp_valid;
   logic [95:0] req_addr, req_wdata;
   logic [11:0] req_wstrb;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        arvalid, arready, awvalid, awready;
   logic        wvalid, wready, wlast, rvalid, rready, rlast;
   logic        bvalid, bready;
   logic [31:0] araddr, awaddr;
   logic [3:0]  arid, awid, rid, bid;
   logic [7:0]  arlen, awlen, wstrb;
   logic [2:0]  arsize, awsize;
   logic [1:0]  arburst, awburst, rresp, bresp;
   logic [63:0] rdata, wdata;

   int checks = 0;
   int errors = 0;

   ysyx_axi_arbiter #(.ADDR_W(32), .NREQ(3), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .io_master_arvalid(arvalid), .io_master_arready(arready),
      .io_master_araddr(araddr), .io_master_arid(arid),
      .io_master_arlen(arlen), .io_master_arsize(arsize),
      .io_master_arburst(arburst),
      .io_master_rvalid(rvalid), .io_master_rready(rready),
      .io_master_rresp(rresp), .io_master_rdata(rdata),
      .io_master_rlast(rlast), .io_master_rid(rid),
      .io_master_awvalid(awvalid), .io_master_awready(awready),
      .io_master_awaddr(awaddr), .io_master_awid(awid),
      .io_master_awlen(awlen), .io_master_awsize(awsize),
      .io_master_awburst(awburst),
      .io_master_wvalid(wvalid), .io_master_wready(wready),
      .io_master_wdata(wdata), .io_master_wstrb(wstrb),
      .io_master_wlast(wlast),
      .io_master_bvalid(bvalid), .io_master_bready(bready),
      .io_master_bresp(bresp), .io_master_bid(bid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // present one request at a falling edge; return in the ADDR cycle
   task automatic issue(input int idx, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
      logic [2:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      req_valid = oh;
      req_write[idx] = wr;
      req_addr[idx*32 +: 32] = a;
      req_wdata[idx*32 +: 32] = d;
      req_wstrb[idx*4 +: 4] = m;
      #1 chk("req_ready", req_ready, oh);
      @(negedge clk);
      req_valid = '0;
   endtask

   task automatic do_load(input int idx, input logic [31:0] a,
                          input logic [3:0] m, input logic [63:0] rd,
                          input logic [2:0] esz, input logic [31:0] erd);
      logic [2:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      issue(idx, 1'b0, a, 32'h0, m);
      #1;
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, a);
      chk("arsize", arsize, esz);
      chk("arid", arid, idx);
      chk("arlen_burst", {arlen, arburst}, {8'd0, 2'b01});
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      #1;
      chk("ld_rready", rready, 1);
      chk("ld_arvalid_off", arvalid, 0);
      chk("ld_rsp_early", rsp_valid, 0);
      rvalid = 1'b1;
      rdata = rd;
      rresp = 2'b00;
      @(negedge clk);
      rvalid = 1'b0;
      #1;
      chk("ld_rsp_valid", rsp_valid, oh);
      chk("ld_rsp_rdata", rsp_rdata, erd);
      chk("ld_rsp_err", rsp_err, 0);
      @(negedge clk);
      chk("ld_rsp_pulse", rsp_valid, 0);
   endtask

   task automatic do_store(input int idx, input logic [31:0] a,
                           input logic [3:0] m, input logic [31:0] d,
                           input bit split, input logic [1:0] br,
                           input logic [2:0] esz, input logic [7:0] estrb);
      logic [2:0] oh;
      oh = '0;
      oh[idx] = 1'b1;
      issue(idx, 1'b1, a, d, m);
      #1;
      chk("aw_w_valid", {awvalid, wvalid, wlast}, 3'b111);
      chk("awaddr", awaddr, a);
      chk("awsize", awsize, esz);
      chk("awid", awid, idx);
      chk("wstrb", wstrb, estrb);
      chk("wdata", wdata, {d, d});
      if (split) begin
         awready = 1'b1;
         @(negedge clk);
         awready = 1'b0;
         #1 chk("aw_dropped", {awvalid, wvalid}, 2'b01);
         wready = 1'b1;
         @(negedge clk);
         wready = 1'b0;
      end else begin
         awready = 1'b1;
         wready = 1'b1;
         @(negedge clk);
         awready = 1'b0;
         wready = 1'b0;
      end
      #1;
      chk("st_bready", bready, 1);
      chk("st_valids_off", {awvalid, wvalid}, 2'b00);
      chk("st_rsp_early", rsp_valid, 0);
      bvalid = 1'b1;
      bresp = br;
      @(negedge clk);
      bvalid = 1'b0;
      #1;
      chk("st_rsp_valid", rsp_valid, oh);
      chk("st_rsp_err", rsp_err, (br != 2'b00));
      chk("st_rsp_rdata", rsp_rdata, 0);
      @(negedge clk);
   endtask

   initial begin
      logic [2:0] gexp [6];
      logic [2:0] gseen [6];
      int gcyc [6];
      int ng;
      int n;
      bit done;
      gexp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      rst = 1'b1;
      req_valid = '0; req_write = '0; req_addr = '0;
      req_wdata = '0; req_wstrb = '0;
      arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
      rdata = '0; rresp = '0; bresp = '0; rlast = 1'b1; rid = '0; bid = '0;

      do_reset();
      rst = 1'b1;
      #1;
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp", {rsp_valid, rsp_err}, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_axi_valids", {arvalid, awvalid, wvalid}, 0);
      @(negedge clk);
      rst = 1'b0;

      do_load(1, 32'h8000_0004, 4'hF, 64'h1122334455667788, 3'd2, 32'h11223344);
      do_store(0, 32'h8000_0006, 4'b0011, 32'h0000ABCD, 1'b1, 2'b10,
               3'd1, 8'h30);
      do_store(2, 32'h8000_0008, 4'hF, 32'h12345678, 1'b0, 2'b00,
               3'd2, 8'h0F);
      do_load(0, 32'h8000_0010, 4'b0100, 64'hDEADBEEF_CAFEF00D,
              3'd0, 32'hCAFEF00D);

      // all three requesters asserted continuously
      do_reset();
      req_valid = 3'b111;
      req_write = 3'b000;
      req_wstrb = 12'hFFF;
      arready = 1'b1;
      rvalid = 1'b1;
      rdata = 64'h0;
      ng = 0;
      for (int c = 0; c < 60 && ng < 6; c++) begin
         #1;
         if (req_ready != 3'b000) begin
            gseen[ng] = req_ready;
            gcyc[ng] = c;
            ng++;
         end
         @(negedge clk);
      end
      req_valid = '0;
      repeat (3) @(negedge clk);
      arready = 1'b0;
      rvalid = 1'b0;
      chk("rr_count", ng, 6);
      for (int i = 0; i < ng; i++) chk($sformatf("rr_grant%0d", i),
                                       gseen[i], gexp[i]);
      if (ng >= 2) chk("rr_gap", gcyc[1] - gcyc[0], 3);

      // reset while waiting in DATA
      do_reset();
      issue(2, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      #1 chk("rd_rready", rready, 1);
      rst = 1'b1;
      rvalid = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rvalid = 1'b0;
      #1;
      chk("rd_no_rsp", rsp_valid, 0);
      chk("rd_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
      @(negedge clk);
      chk("rd_no_rsp2", rsp_valid, 0);

      // slave never accepts the read address
      do_reset();
      issue(1, 1'b0, 32'h8000_0020, 32'h0, 4'hF);
`ifdef YSYX_ARB_TIMEOUT_EN
      n = 0;
      done = 1'b0;
      while (!done && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (rsp_valid != 3'b000) done = 1'b1;
      end
      chk("to_fired", done, 1);
      chk("to_cycle", n, 16);
      chk("to_rsp", {rsp_valid, rsp_err}, {3'b010, 1'b1});
      chk("to_rdata", rsp_rdata, 0);
      chk("to_arvalid", arvalid, 0);
`else
      n = 0;
      done = 1'b0;
      repeat (1000) begin
         @(negedge clk);
         n++;
         if (!arvalid || rsp_valid != 3'b000) done = 1'b1;
      end
      chk("hang_cycles", n, 1000);
      chk("hang_arvalid", {arvalid, done}, 2'b10);
`endif
      do_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
